// File: rtl/read_arbiter.sv
// Two-requester (fetch / data-load) round-robin arbiter onto a single AXI-lite read channel.
// One transaction outstanding at a time; responses are routed back to the granted requester.
module read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_valid,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_ready,
  output logic                  f_rvalid,
  output logic [DATA_WIDTH-1:0] f_rdata,
  output logic [1:0]            f_rresp,
  input  logic                  d_valid,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_ready,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [1:0]            d_rresp,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddress,
  output logic [2:0]            arprot,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  state_t state, state_nxt;
  owner_t owner, last_grant;
  logic   grant_f, grant_d, complete;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    state_nxt = state;
    grant_f   = 1'b0;
    grant_d   = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        // Grants are suppressed while reset is held so no ready pulses during reset.
        if (reset) begin
          if (f_valid && (!d_valid || last_grant == OWN_DATA)) grant_f = 1'b1;
          else if (d_valid)                                    grant_d = 1'b1;
          if (grant_f || grant_d) state_nxt = ADDR;
        end
      end
      ADDR: begin
        // rvalid without arready is a protocol violation by the slave and is ignored.
        if (arready) begin
          if (rvalid) begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (rvalid) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign f_ready = grant_f;
  assign d_ready = grant_d;
  assign arvalid = (state == ADDR);
  assign rready  = (state == ADDR) || (state == DATA);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_FETCH;
      last_grant <= OWN_DATA;
      araddress  <= '0;
      arprot     <= '0;
      f_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
      f_rdata    <= '0;
      d_rdata    <= '0;
      f_rresp    <= '0;
      d_rresp    <= '0;
    end else begin
      state    <= state_nxt;
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if (grant_f) begin
        owner      <= OWN_FETCH;
        last_grant <= OWN_FETCH;
        araddress  <= f_addr;
        arprot     <= 3'b101;
      end else if (grant_d) begin
        owner      <= OWN_DATA;
        last_grant <= OWN_DATA;
        araddress  <= d_addr;
        arprot     <= 3'b001;
      end
      if (complete) begin
        if (owner == OWN_FETCH) begin
          f_rvalid <= 1'b1;
          f_rdata  <= rdata;
          f_rresp  <= rresp;
        end else begin
          d_rvalid <= 1'b1;
          d_rdata  <= rdata;
          d_rresp  <= rresp;
        end
      end
    end
  end

endmodule

// File: tb/tb_read_arbiter.sv
// Directed self-checking bench for read_arbiter: one task per scenario, hand-computed expectations.
module tb_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_valid, d_valid, f_ready, d_ready;
  logic [31:0] f_addr, d_addr;
  logic        f_rvalid, d_rvalid;
  logic [31:0] f_rdata, d_rdata;
  logic [1:0]  f_rresp, d_rresp;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] araddress, rdata;
  logic [2:0]  arprot;
  logic [1:0]  rresp;

  int n_checks = 0;
  int n_fail   = 0;

  read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_rresp(f_rresp),
    .d_valid(d_valid), .d_addr(d_addr), .d_ready(d_ready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rresp(d_rresp),
    .arvalid(arvalid), .arready(arready), .araddress(araddress), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_valid = 0; f_addr = '0; d_valid = 0; d_addr = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    tick(); tick();
    reset = 1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset   = 0;
    f_valid = 1; d_valid = 1; f_addr = 32'h10; d_addr = 32'h20;
    tick(); tick();
    n_checks++;
    if ({f_ready, d_ready} !== 2'b00) begin
      $display("FAIL reset_ready: got %b exp 00", {f_ready, d_ready}); n_fail++;
    end
    n_checks++;
    if ({arvalid, rready, f_rvalid, d_rvalid} !== 4'b0000) begin
      $display("FAIL reset_ctrl: got %b exp 0000", {arvalid, rready, f_rvalid, d_rvalid}); n_fail++;
    end
    n_checks++;
    if ({araddress, arprot, f_rdata, d_rdata, f_rresp, d_rresp} !== '0) begin
      $display("FAIL reset_data: araddress=%h arprot=%b f_rdata=%h d_rdata=%h exp all 0",
               araddress, arprot, f_rdata, d_rdata); n_fail++;
    end
    idle_inputs();
    reset = 1;
    #1;
  endtask

  task automatic test_fetch_basic();
    do_reset();
    f_valid = 1; f_addr = 32'h0;
    #1;
    n_checks++;
    if ({f_ready, d_ready} !== 2'b10) begin
      $display("FAIL basic_grant: got %b exp 10", {f_ready, d_ready}); n_fail++;
    end
    tick();
    f_valid = 0; arready = 1; rvalid = 1; rdata = 32'h00000073; rresp = 2'b00;
    #1;
    n_checks++;
    if ({arvalid, rready, arprot, araddress} !== {1'b1, 1'b1, 3'b101, 32'h0}) begin
      $display("FAIL basic_addr: arvalid=%b rready=%b arprot=%b araddress=%h exp 1 1 101 0",
               arvalid, rready, arprot, araddress); n_fail++;
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if ({f_rvalid, d_rvalid, f_rdata, f_rresp} !== {1'b1, 1'b0, 32'h00000073, 2'b00}) begin
      $display("FAIL basic_resp: f_rvalid=%b d_rvalid=%b f_rdata=%h f_rresp=%b exp 1 0 00000073 00",
               f_rvalid, d_rvalid, f_rdata, f_rresp); n_fail++;
    end
    n_checks++;
    if ({arvalid, rready} !== 2'b00) begin
      $display("FAIL basic_idle: got %b exp 00", {arvalid, rready}); n_fail++;
    end
    tick();
    n_checks++;
    if ({f_rvalid, f_rdata} !== {1'b0, 32'h00000073}) begin
      $display("FAIL basic_pulse_hold: f_rvalid=%b f_rdata=%h exp 0 00000073", f_rvalid, f_rdata); n_fail++;
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    f_valid = 1; f_addr = 32'h10; d_valid = 1; d_addr = 32'h20;
    #1;
    n_checks++;
    if ({f_ready, d_ready} !== 2'b10) begin
      $display("FAIL rr_first: got %b exp 10", {f_ready, d_ready}); n_fail++;
    end
    tick();
    f_valid = 0; arready = 1; rvalid = 1; rdata = 32'h1;
    #1;
    n_checks++;
    if ({araddress, arprot, d_ready} !== {32'h10, 3'b101, 1'b0}) begin
      $display("FAIL rr_first_addr: araddress=%h arprot=%b d_ready=%b exp 10 101 0",
               araddress, arprot, d_ready); n_fail++;
    end
    tick();
    arready = 0; rvalid = 0; f_valid = 1; f_addr = 32'h30;
    #1;
    n_checks++;
    if ({f_ready, d_ready} !== 2'b01) begin
      $display("FAIL rr_second: got %b exp 01", {f_ready, d_ready}); n_fail++;
    end
    tick();
    d_valid = 0; arready = 1; rvalid = 1; rdata = 32'h2;
    #1;
    n_checks++;
    if ({araddress, arprot} !== {32'h20, 3'b001}) begin
      $display("FAIL rr_second_addr: araddress=%h arprot=%b exp 20 001", araddress, arprot); n_fail++;
    end
    tick();
    arready = 0; rvalid = 0; d_valid = 1; d_addr = 32'h40;
    #1;
    n_checks++;
    if ({d_rvalid, d_rdata, f_ready, d_ready} !== {1'b1, 32'h2, 2'b10}) begin
      $display("FAIL rr_third: d_rvalid=%b d_rdata=%h ready=%b exp 1 2 10",
               d_rvalid, d_rdata, {f_ready, d_ready}); n_fail++;
    end
    tick();
    #1;
    n_checks++;
    if ({araddress, arprot} !== {32'h30, 3'b101}) begin
      $display("FAIL rr_third_addr: araddress=%h arprot=%b exp 30 101", araddress, arprot); n_fail++;
    end
  endtask

  task automatic test_data_slow();
    do_reset();
    d_valid = 1; d_addr = 32'h400;
    #1;
    n_checks++;
    if ({f_ready, d_ready} !== 2'b01) begin
      $display("FAIL slow_grant: got %b exp 01", {f_ready, d_ready}); n_fail++;
    end
    tick();
    d_valid = 0; arready = 1;
    #1;
    n_checks++;
    if ({arvalid, araddress, arprot} !== {1'b1, 32'h400, 3'b001}) begin
      $display("FAIL slow_addr: arvalid=%b araddress=%h arprot=%b exp 1 400 001",
               arvalid, araddress, arprot); n_fail++;
    end
    tick();
    arready = 0;
    #1;
    n_checks++;
    if ({arvalid, rready} !== 2'b01) begin
      $display("FAIL slow_data1: arvalid/rready=%b exp 01", {arvalid, rready}); n_fail++;
    end
    tick();
    rvalid = 1; rdata = 32'hDEADBEEF; rresp = 2'b11;
    #1;
    n_checks++;
    if ({arvalid, rready, d_rvalid} !== 3'b010) begin
      $display("FAIL slow_data2: arvalid/rready/d_rvalid=%b exp 010", {arvalid, rready, d_rvalid}); n_fail++;
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if ({d_rvalid, f_rvalid, d_rdata, d_rresp, rready} !== {2'b10, 32'hDEADBEEF, 2'b11, 1'b0}) begin
      $display("FAIL slow_resp: d_rvalid=%b f_rvalid=%b d_rdata=%h d_rresp=%b rready=%b exp 1 0 deadbeef 11 0",
               d_rvalid, f_rvalid, d_rdata, d_rresp, rready); n_fail++;
    end
  endtask

  task automatic test_addr_stall();
    do_reset();
    f_valid = 1; f_addr = 32'h1234;
    tick();
    f_valid = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin rvalid = 1; rdata = 32'hBAD; end
      else        rvalid = 0;
      #1;
      n_checks++;
      if ({arvalid, rready, araddress, arprot, f_rvalid} !== {2'b11, 32'h1234, 3'b101, 1'b0}) begin
        $display("FAIL stall_cycle%0d: arvalid=%b rready=%b araddress=%h arprot=%b f_rvalid=%b exp 1 1 1234 101 0",
                 i, arvalid, rready, araddress, arprot, f_rvalid); n_fail++;
      end
      tick();
    end
    rvalid = 0; arready = 1;
    tick();
    arready = 0; rvalid = 1; rdata = 32'h55;
    #1;
    n_checks++;
    if ({arvalid, f_rvalid} !== 2'b00) begin
      $display("FAIL stall_stray: arvalid/f_rvalid=%b exp 00", {arvalid, f_rvalid}); n_fail++;
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if ({f_rvalid, f_rdata} !== {1'b1, 32'h55}) begin
      $display("FAIL stall_resp: f_rvalid=%b f_rdata=%h exp 1 00000055", f_rvalid, f_rdata); n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    f_valid = 1; f_addr = 32'h8;
    tick();
    f_valid = 0; arready = 1; rvalid = 1; rdata = 32'h99; rresp = 2'b10;
    tick();
    idle_inputs();
    d_valid = 1; d_addr = 32'h80;
    tick();
    d_valid = 0; arready = 1;
    tick();
    arready = 0;
    reset = 0;
    tick();
    reset = 1; rvalid = 1; rdata = 32'h77;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if ({arvalid, rready, f_ready, d_ready, f_rvalid, d_rvalid} !== 6'b0) begin
        $display("FAIL rstmid_ctrl%0d: got %b exp 000000", i,
                 {arvalid, rready, f_ready, d_ready, f_rvalid, d_rvalid}); n_fail++;
      end
      n_checks++;
      if ({araddress, arprot, f_rdata, d_rdata, f_rresp, d_rresp} !== '0) begin
        $display("FAIL rstmid_data%0d: araddress=%h arprot=%b f_rdata=%h d_rdata=%h f_rresp=%b exp all 0",
                 i, araddress, arprot, f_rdata, d_rdata, f_rresp); n_fail++;
      end
      tick();
    end
    rvalid = 0;
    f_valid = 1; d_valid = 1;
    #1;
    n_checks++;
    if ({f_ready, d_ready} !== 2'b10) begin
      $display("FAIL rstmid_lastgrant: got %b exp 10", {f_ready, d_ready}); n_fail++;
    end
    do_reset();
  endtask

  task automatic test_wait_busy();
    do_reset();
    f_valid = 1; f_addr = 32'h200;
    tick();
    f_valid = 0; arready = 1;
    tick();
    arready = 0; d_valid = 1; d_addr = 32'h300;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (d_ready !== 1'b0) begin
        $display("FAIL busy_wait%0d: d_ready=%b exp 0", i, d_ready); n_fail++;
      end
      tick();
    end
    rvalid = 1; rdata = 32'hABC;
    #1;
    n_checks++;
    if (d_ready !== 1'b0) begin
      $display("FAIL busy_complete: d_ready=%b exp 0", d_ready); n_fail++;
    end
    tick();
    rvalid = 0;
    #1;
    n_checks++;
    if ({f_rvalid, f_rdata, d_ready, f_ready} !== {1'b1, 32'hABC, 2'b10}) begin
      $display("FAIL busy_after: f_rvalid=%b f_rdata=%h d_ready=%b f_ready=%b exp 1 abc 1 0",
               f_rvalid, f_rdata, d_ready, f_ready); n_fail++;
    end
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    test_reset();
    test_fetch_basic();
    test_round_robin();
    test_data_slow();
    test_addr_stall();
    test_reset_mid();
    test_wait_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/read_arbiter.md
READ_ARBITER -- requirements
Module: read_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, request and AR address width.
REQ-002 Parameter DATA_WIDTH, default 32, request and R data width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on posedge clk, asserted when 0.
REQ-005 f_valid  input  1  fetch requester: request pending; held with f_addr until f_ready.
REQ-006 f_addr  input  ADDR_WIDTH  fetch request address.
REQ-007 f_ready  output  1  fetch request accepted this cycle (one-cycle pulse).
REQ-008 f_rvalid  output  1  fetch response valid (one-cycle pulse).
REQ-009 f_rdata  output  DATA_WIDTH  fetch response data.
REQ-010 f_rresp  output  2  fetch response code (copy of rresp).
REQ-011 d_valid, d_addr, d_ready, d_rvalid, d_rdata, d_rresp  same directions/widths/meanings as REQ-005..REQ-010, data-load requester.
REQ-012 arvalid  output  1  AXI-lite read address valid.
REQ-013 arready  input  1  AXI-lite read address ready.
REQ-014 araddress  output  ADDR_WIDTH  read address.
REQ-015 arprot  output  3  3'b101 for fetch grant, 3'b001 for data grant.
REQ-016 rvalid  input  1  read data valid.
REQ-017 rready  output  1  read data ready.
REQ-018 rdata  input  DATA_WIDTH  read data.
REQ-019 rresp  input  2  read response code.

Function
REQ-020 States: IDLE, ADDR, DATA; exactly one transaction outstanding at any time.
REQ-021 IDLE: if any of f_valid/d_valid high, grant one, pulse its ready, register address/arprot/owner, go ADDR next cycle.
REQ-022 Arbitration round-robin: both requesting -> grant the one not granted last; single requester always granted.
REQ-023 last_grant updates only on grant; reset value = data, so fetch wins first contention.
REQ-024 ADDR: arvalid=1, rready=1; araddress/arprot stable until arready.
REQ-025 ADDR, arready=1 and rvalid=1 same cycle: complete transaction, go IDLE (slave may return data on the AR handshake cycle).
REQ-026 ADDR, arready=1, rvalid=0: go DATA; arvalid drops next cycle.
REQ-027 ADDR, rvalid=1 without arready: ignored, no response delivered.
REQ-028 DATA: arvalid=0, rready=1; on rvalid go IDLE; no timeout.
REQ-029 Completion: owner's x_rvalid pulses 1 cycle after rvalid&&rready, x_rdata/x_rresp registered from rdata/rresp, held until next completion.
REQ-030 Non-owner rvalid never pulses; both x_rvalid never high together.
REQ-031 rresp passed through unmodified, including 2'b10/2'b11; no retry.
REQ-032 rready=0 and arvalid=0 in IDLE.
REQ-033 New grant allowed in the IDLE cycle following completion; minimum request-to-response latency 3 cycles (grant, ADDR with arready+rvalid, response pulse).
REQ-034 Requests arriving while not IDLE wait; x_ready never pulses outside IDLE.

Reset
REQ-035 reset=0 at posedge: state IDLE; arvalid, rready, f_ready, d_ready, f_rvalid, d_rvalid = 0; araddress, arprot, f_rdata, d_rdata, f_rresp, d_rresp = 0; last_grant = data.
REQ-036 Reset mid-transaction abandons it: no x_rvalid for it, slave responses arriving after reset released ignored while IDLE.

Verification
REQ-037 f_valid=1, f_addr=0x0, slave arready+rvalid same cycle, rdata=0x00000073 -> f_ready pulse, arprot=3'b101, f_rvalid pulse with f_rdata=0x00000073, f_rresp=2'b00, 3-cycle latency.
REQ-038 f_valid and d_valid both high from reset, addrs 0x10/0x20 -> fetch granted first (araddress 0x10), then data (0x20, arprot 3'b001); third contention -> fetch again.
REQ-039 d_valid, d_addr=0x400, slave arready then rvalid 2 cycles later with rresp=2'b11 -> state ADDR->DATA->IDLE, d_rvalid with d_rresp=2'b11, f_rvalid stays 0.
REQ-040 arready withheld 5 cycles -> arvalid, araddress, arprot stable all 5 cycles, rready=1 throughout.
REQ-041 reset=0 asserted in DATA, then slave rvalid=1 after release -> no f_rvalid/d_rvalid, all outputs at REQ-035 values.
REQ-042 d_valid raised during fetch DATA -> d_ready pulses only in IDLE after fetch response.
